// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES-128 inverse cipher controller.
// One round per clock over a single 128-bit state register. Round keys come
// from an external key store addressed by rk_addr in the order 10,9,...,1,0.
// Byte layout everywhere: bits [127:96] = column 0, byte [127:120] = row 0.

// Inverse S-box lookup for one byte.
module aes_inv_sbox (
   input  logic [7:0] a_i,
   output logic [7:0] y_o
);
   // Row 0 of the table sits in the most significant bits, so element 255
   // holds InvSbox[0x00]. That is why the lookup indexes with ~a_i.
   localparam logic [255:0][7:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   assign y_o = INV_SBOX[~a_i];
endmodule

// InvSubBytes: sixteen parallel inverse S-boxes.
module aes_inv_sub_bytes (
   input  logic [127:0] data_i,
   output logic [127:0] data_o
);
   for (genvar i = 0; i < 16; i++) begin : g_sbox
      aes_inv_sbox u_sbox (
         .a_i (data_i[8*i +: 8]),
         .y_o (data_o[8*i +: 8])
      );
   end
endmodule

// InvShiftRows: row r is rotated right by r columns.
module aes_inv_shift_rows (
   input  logic [127:0] data_i,
   output logic [127:0] data_o
);
   // Output byte (row r, column c) comes from input byte (row r, column c-r mod 4).
   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign data_o[127 - 8*(4*c + r) -: 8] =
            data_i[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
      end
   end
endmodule

// InvMixColumns for one 32-bit column (row 0 in the top byte).
module aes_inv_mix_column (
   input  logic [31:0] col_i,
   output logic [31:0] col_o
);
   // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Multiply by a 4-bit constant built from the powers x, x^2, x^3.
   function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
      logic [7:0] x2, x4, x8;
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return (k[0] ? b : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
             (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
   endfunction

   logic [7:0] a0, a1, a2, a3;
   assign {a0, a1, a2, a3} = col_i;

   assign col_o[31:24] = gmul(a0, 4'd14) ^ gmul(a1, 4'd11) ^ gmul(a2, 4'd13) ^ gmul(a3, 4'd9);
   assign col_o[23:16] = gmul(a0, 4'd9)  ^ gmul(a1, 4'd14) ^ gmul(a2, 4'd11) ^ gmul(a3, 4'd13);
   assign col_o[15:8]  = gmul(a0, 4'd13) ^ gmul(a1, 4'd9)  ^ gmul(a2, 4'd14) ^ gmul(a3, 4'd11);
   assign col_o[7:0]   = gmul(a0, 4'd11) ^ gmul(a1, 4'd13) ^ gmul(a2, 4'd9)  ^ gmul(a3, 4'd14);
endmodule

// Round controller top.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The input side accepts only in IDLE with key_ready set. The
// output side holds out_valid and out_data stable until out_ready is seen.
module aes_inv_round_ctrl #(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         key_ready,
   input  logic         in_valid,
   input  logic [127:0] in_data,
   output logic         in_ready,
   output logic [3:0]   rk_addr,
   input  logic [127:0] rk_data,
   output logic         out_valid,
   output logic [127:0] out_data,
   input  logic         out_ready,
   output logic         busy
);
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      INIT  = 3'd1,
      ROUND = 3'd2,
      FINAL = 3'd3,
      DONE  = 3'd4
   } fsm_e;

   localparam logic [3:0] LAST_KEY   = 4'(NR);
   localparam logic [3:0] FIRST_ROUND = 4'(NR - 1);

   fsm_e         fsm_q;
   logic [127:0] state_q;
   logic [3:0]   round_q;
   logic [3:0]   rk_addr_q;
   logic         out_valid_q;
   logic         busy_q;

   // Shared datapath. ROUND and FINAL both use InvSubBytes(InvShiftRows(s)) ^ key.
   // ROUND then applies InvMixColumns to that sum.
   logic [127:0] inv_sr;
   logic [127:0] inv_sb;
   logic [127:0] add_key;
   logic [127:0] state_round_d;
   logic [127:0] state_init_d;

   aes_inv_shift_rows u_isr (.data_i(state_q), .data_o(inv_sr));
   aes_inv_sub_bytes  u_isb (.data_i(inv_sr),  .data_o(inv_sb));

   assign add_key      = inv_sb ^ rk_data;
   assign state_init_d = state_q ^ rk_data;

   for (genvar c = 0; c < 4; c++) begin : g_imc
      aes_inv_mix_column u_imc (
         .col_i (add_key[127 - 32*c -: 32]),
         .col_o (state_round_d[127 - 32*c -: 32])
      );
   end

   // The sequencer registers every output. The key store sees each new
   // address one cycle before the state that consumes that key.
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q       <= IDLE;
         state_q     <= '0;
         round_q     <= '0;
         rk_addr_q   <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (fsm_q)
            IDLE: begin
               if (in_valid && in_ready) begin
                  state_q   <= in_data;
                  rk_addr_q <= LAST_KEY;
                  round_q   <= FIRST_ROUND;
                  busy_q    <= 1'b1;
                  fsm_q     <= INIT;
               end
            end
            INIT: begin
               state_q   <= state_init_d;
               rk_addr_q <= FIRST_ROUND;
               fsm_q     <= ROUND;
            end
            ROUND: begin
               state_q <= state_round_d;
               if (round_q == 4'd1) begin
                  rk_addr_q <= 4'd0;
                  fsm_q     <= FINAL;
               end else begin
                  round_q   <= round_q - 4'd1;
                  rk_addr_q <= rk_addr_q - 4'd1;
               end
            end
            FINAL: begin
               state_q     <= add_key;
               out_valid_q <= 1'b1;
               fsm_q       <= DONE;
            end
            DONE: begin
               // Returning to IDLE only here means no block is accepted in
               // the same cycle as the output handshake.
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  fsm_q       <= IDLE;
               end
            end
            default: begin
               fsm_q       <= IDLE;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = (fsm_q == IDLE) & key_ready;
   assign rk_addr   = rk_addr_q;
   assign out_valid = out_valid_q;
   assign out_data  = state_q;
   assign busy      = busy_q;
endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Directed testbench for aes_inv_round_ctrl using the FIPS-197 C.1 vector.
module tb_aes_inv_round_ctrl;
   localparam logic [127:0] CT     = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] ISTART = 128'h7ad5fda789ef4e272bca100b3d9ff59f;

   logic         clk = 1'b0;
   logic         rst;
   logic         key_ready;
   logic         in_valid;
   logic [127:0] in_data;
   logic         in_ready;
   logic [3:0]   rk_addr;
   logic [127:0] rk_data;
   logic         out_valid;
   logic [127:0] out_data;
   logic         out_ready;
   logic         busy;

   int checks   = 0;
   int failures = 0;

   logic [127:0] ks [0:10];

   // Clock and reset block.
   always #5 clk = ~clk;

   // The key store returns the key for the current rk_addr value.
   always_comb begin
      rk_data = '0;
      if (rk_addr <= 4'd10) rk_data = ks[rk_addr];
   end

   aes_inv_round_ctrl #(.NR(10)) dut (
      .clk       (clk),
      .rst       (rst),
      .key_ready (key_ready),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .rk_addr   (rk_addr),
      .rk_data   (rk_data),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .busy      (busy)
   );

   // Wait, at falling edges, until out_valid is seen or the budget runs out.
   task automatic wait_out_valid(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (out_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; key_ready = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (out_data !== 128'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
      checks++; if (rk_addr !== 4'd0) begin failures++; $display("FAIL reset_rk_addr got=%0d exp=0", rk_addr); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_hold_busy got=%b exp=0", busy); end
   endtask

   task automatic test_c1_trace;
      in_data = CT; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL c1_in_ready got=%b exp=1", in_ready); end
      for (int n = 1; n <= 13; n++) begin
         @(negedge clk);
         if (n == 1) begin
            checks++; if (out_data !== CT) begin failures++; $display("FAIL c1_loaded got=%h exp=%h", out_data, CT); end
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL c1_busy got=%b exp=1", busy); end
            in_valid = 1'b0;
         end
         if (n == 2) begin
            checks++; if (out_data !== ISTART) begin failures++; $display("FAIL c1_init_xor got=%h exp=%h", out_data, ISTART); end
         end
         if (n <= 11) begin
            checks++; if (rk_addr !== 4'(11 - n)) begin failures++; $display("FAIL c1_rk_addr n=%0d got=%0d exp=%0d", n, rk_addr, 11 - n); end
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL c1_early_valid n=%0d got=%b exp=0", n, out_valid); end
         end
         if (n == 12) begin
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL c1_latency got=%b exp=1", out_valid); end
            checks++; if (out_data !== PT) begin failures++; $display("FAIL c1_plaintext got=%h exp=%h", out_data, PT); end
            checks++; if (rk_addr !== 4'd0) begin failures++; $display("FAIL c1_rk_hold_done got=%0d exp=0", rk_addr); end
         end
         if (n == 13) begin
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL c1_valid_drop got=%b exp=0", out_valid); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL c1_idle_busy got=%b exp=0", busy); end
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL c1_idle_ready got=%b exp=1", in_ready); end
            checks++; if (rk_addr !== 4'd0) begin failures++; $display("FAIL c1_rk_hold_idle got=%0d exp=0", rk_addr); end
         end
      end
   endtask

   task automatic test_gating;
      bit ok;
      key_ready = 1'b0; in_data = CT; in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL gate_in_ready i=%0d got=%b exp=0", i, in_ready); end
         checks++; if (busy !== 1'b0) begin failures++; $display("FAIL gate_busy i=%0d got=%b exp=0", i, busy); end
      end
      key_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL gate_release_ready got=%b exp=1", in_ready); end
      @(negedge clk);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL gate_accept_busy got=%b exp=1", busy); end
      in_valid = 1'b0;
      wait_out_valid(20, ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL gate_timeout got=%b exp=1", ok); end
      checks++; if (out_data !== PT) begin failures++; $display("FAIL gate_plaintext got=%h exp=%h", out_data, PT); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL gate_drain_busy got=%b exp=0", busy); end
   endtask

   task automatic test_backpressure;
      bit ok;
      out_ready = 1'b0; in_data = CT; in_valid = 1'b1; key_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      key_ready = 1'b0;
      wait_out_valid(20, ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL bp_timeout got=%b exp=1", ok); end
      in_valid = 1'b1; in_data = ~CT; key_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid i=%0d got=%b exp=1", i, out_valid); end
         checks++; if (out_data !== PT) begin failures++; $display("FAIL bp_data i=%0d got=%h exp=%h", i, out_data, PT); end
         checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready i=%0d got=%b exp=0", i, in_ready); end
         checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bp_busy i=%0d got=%b exp=1", i, busy); end
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_release_busy got=%b exp=0", busy); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_reset_midop;
      bit ok;
      out_ready = 1'b1; in_data = CT; in_valid = 1'b1; key_ready = 1'b1;
      for (int n = 1; n <= 6; n++) begin
         @(negedge clk);
         if (n == 1) in_valid = 1'b0;
      end
      checks++; if (rk_addr !== 4'd5) begin failures++; $display("FAIL rmid_round5_addr got=%0d exp=5", rk_addr); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", out_valid); end
      checks++; if (out_data !== 128'h0) begin failures++; $display("FAIL rmid_data got=%h exp=0", out_data); end
      checks++; if (rk_addr !== 4'd0) begin failures++; $display("FAIL rmid_rk_addr got=%0d exp=0", rk_addr); end
      rst = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      wait_out_valid(20, ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rmid_timeout got=%b exp=1", ok); end
      checks++; if (out_data !== PT) begin failures++; $display("FAIL rmid_plaintext got=%h exp=%h", out_data, PT); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      out_ready = 1'b1; in_data = CT; in_valid = 1'b1; key_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_first_ready got=%b exp=1", in_ready); end
      for (int n = 1; n <= 25; n++) begin
         @(negedge clk);
         if (n <= 11) begin
            checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL b2b_first_run n=%0d busy=%b valid=%b exp busy=1 valid=0", n, busy, out_valid); end
         end
         if (n == 12) begin
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_first_valid got=%b exp=1", out_valid); end
            checks++; if (out_data !== PT) begin failures++; $display("FAIL b2b_first_data got=%h exp=%h", out_data, PT); end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_no_turnaround got=%b exp=0", in_ready); end
         end
         if (n == 13) begin
            checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL b2b_idle_gap ready=%b busy=%b exp ready=1 busy=0", in_ready, busy); end
         end
         if (n == 14) begin
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_second_accept got=%b exp=1", busy); end
            checks++; if (out_data !== CT) begin failures++; $display("FAIL b2b_second_load got=%h exp=%h", out_data, CT); end
            checks++; if (rk_addr !== 4'd10) begin failures++; $display("FAIL b2b_second_addr got=%0d exp=10", rk_addr); end
            in_valid = 1'b0;
         end
         if (n == 24) begin
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_second_early got=%b exp=0", out_valid); end
         end
         if (n == 25) begin
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_second_valid got=%b exp=1", out_valid); end
            checks++; if (out_data !== PT) begin failures++; $display("FAIL b2b_second_data got=%h exp=%h", out_data, PT); end
         end
      end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_drain_busy got=%b exp=0", busy); end
   endtask

   // Guard against a stuck run.
   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      ks[0]  = 128'h000102030405060708090a0b0c0d0e0f;
      ks[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
      ks[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
      ks[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
      ks[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
      ks[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
      ks[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
      ks[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
      ks[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
      ks[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
      ks[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;

      test_reset();
      test_c1_trace();
      test_gating();
      test_backpressure();
      test_reset_midop();
      test_back_to_back();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
